// File: rtl/fifo_capture_pkg.sv
// Shared constants for the capture controller: register map, bit positions, FSM encodings.
package fifo_capture_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_LENGTH = 2'd1;
    localparam logic [1:0] ADDR_DECIM  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned CTRL_START_BIT   = 0;
    localparam int unsigned CTRL_ABORT_BIT   = 1;
    localparam int unsigned CTRL_IRQ_CLR_BIT = 2;
    localparam int unsigned CTRL_BUSY_BIT    = 0;

    localparam int unsigned STATUS_DONE_BIT = 16;
    localparam int unsigned STATUS_OVF_BIT  = 17;
    localparam int unsigned STATUS_UDF_BIT  = 18;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_CAPTURE = 2'd1;
    localparam state_t ST_DONE    = 2'd2;

endpackage

// File: rtl/fifo_level_tracker.sv
// Mirror of the capture FIFO occupancy; flags reads issued against an empty FIFO.
module fifo_level_tracker #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned LVL_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clr_flag,
    output logic [LVL_W-1:0] o_level,
    output logic             o_underflow
);

    logic [LVL_W-1:0] r_level;
    logic             r_underflow;

    // A simultaneous write and read cancel out, even at level 0
    always_ff @(posedge clock) begin
        if (reset) begin
            r_level     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (i_clr_flag) begin
                r_underflow <= 1'b0;
            end
            case ({i_inc, i_dec})
                2'b10: begin
                    if (r_level != LVL_W'(DEPTH)) begin
                        r_level <= r_level + LVL_W'(1);
                    end
                end
                2'b01: begin
                    if (r_level != '0) begin
                        r_level <= r_level - LVL_W'(1);
                    end else begin
                        r_underflow <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_level     = r_level;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/fifo_capture_ctrl.sv
// Arms on software start, decimates the Avalon-ST stream and writes LENGTH samples into
// the capture FIFO, then raises a level interrupt; mirrors FIFO occupancy for software.
module fifo_capture_ctrl
    import fifo_capture_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LVL_W   = 8,
    parameter int unsigned DECIM_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        ctrl_address,
    input  logic              ctrl_write,
    input  logic [31:0]       ctrl_writedata,
    input  logic              ctrl_read,
    output logic [31:0]       ctrl_readdata,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    output logic [DATA_W-1:0] fifo_data,
    output logic              fifo_wrreq,
    input  logic              rd_strobe,
    output logic              irq
);

    state_t             r_state, w_state_nxt;
    logic [LVL_W-1:0]   r_length, w_length_nxt;
    logic [LVL_W-1:0]   r_captured, w_captured_nxt;
    logic [DECIM_W-1:0] r_decim, w_decim_nxt;
    logic [DECIM_W-1:0] r_decim_cnt, w_decim_cnt_nxt;
    logic               r_done, w_done_nxt;
    logic               r_ovf, w_ovf_nxt;
    logic               r_irq, w_irq_nxt;
    logic               r_wrreq, w_wrreq_nxt;
    logic [DATA_W-1:0]  r_data, w_data_nxt;
    logic [31:0]        r_rdata, w_rdata_nxt;

    logic               w_ctrl_wr, w_start, w_abort, w_irq_clr, w_clr_flags;
    logic               w_room;
    logic [LVL_W-1:0]   w_captured_inc;
    logic [LVL_W-1:0]   w_level;
    logic               w_underflow;
    logic [31:0]        w_status;
    logic [31:0]        w_ctrl_rd;

    fifo_level_tracker #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_level (
        .clock       (clock),
        .reset       (reset),
        .i_inc       (r_wrreq),
        .i_dec       (rd_strobe),
        .i_clr_flag  (w_clr_flags),
        .o_level     (w_level),
        .o_underflow (w_underflow)
    );

    assign w_ctrl_wr      = ctrl_write && (ctrl_address == ADDR_CTRL);
    assign w_start        = w_ctrl_wr && ctrl_writedata[CTRL_START_BIT];
    assign w_abort        = w_ctrl_wr && ctrl_writedata[CTRL_ABORT_BIT];
    assign w_irq_clr      = w_ctrl_wr && ctrl_writedata[CTRL_IRQ_CLR_BIT];
    assign w_captured_inc = r_captured + LVL_W'(1);
    // A write already in flight is not yet counted by the level mirror
    assign w_room = ({1'b0, w_level} + {{LVL_W{1'b0}}, r_wrreq}) < (LVL_W+1)'(DEPTH);

    // Next-state, register-file and output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_length_nxt    = r_length;
        w_captured_nxt  = r_captured;
        w_decim_nxt     = r_decim;
        w_decim_cnt_nxt = r_decim_cnt;
        w_done_nxt      = r_done;
        w_ovf_nxt       = r_ovf;
        w_irq_nxt       = r_irq;
        w_wrreq_nxt     = 1'b0;
        w_data_nxt      = r_data;
        w_rdata_nxt     = r_rdata;
        w_clr_flags     = 1'b0;
        w_status        = '0;
        w_ctrl_rd       = '0;

        if (ctrl_write && (ctrl_address == ADDR_LENGTH)) begin
            if (ctrl_writedata == 32'd0) begin
                w_length_nxt = LVL_W'(1);
            end else if (ctrl_writedata > 32'(DEPTH)) begin
                w_length_nxt = LVL_W'(DEPTH);
            end else begin
                w_length_nxt = LVL_W'(ctrl_writedata);
            end
        end
        if (ctrl_write && (ctrl_address == ADDR_DECIM)) begin
            w_decim_nxt = ctrl_writedata[DECIM_W-1:0];
        end
        if (w_irq_clr) begin
            w_irq_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start && !w_abort) begin
                    w_state_nxt     = ST_CAPTURE;
                    w_captured_nxt  = '0;
                    w_decim_cnt_nxt = '0;
                    w_done_nxt      = 1'b0;
                    w_ovf_nxt       = 1'b0;
                    w_irq_nxt       = 1'b0;
                    w_clr_flags     = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (snk_valid) begin
                    if (r_decim_cnt == '0) begin
                        w_decim_cnt_nxt = r_decim;
                        w_captured_nxt  = w_captured_inc;
                        if (w_room) begin
                            w_data_nxt  = snk_data;
                            w_wrreq_nxt = 1'b1;
                        end else begin
                            w_ovf_nxt = 1'b1;
                        end
                        if (w_captured_inc == r_length) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                            w_irq_nxt   = 1'b1;
                        end
                    end else begin
                        w_decim_cnt_nxt = r_decim_cnt - DECIM_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_status[LVL_W-1:0]      = w_level;
        w_status[STATUS_DONE_BIT] = r_done;
        w_status[STATUS_OVF_BIT]  = r_ovf;
        w_status[STATUS_UDF_BIT]  = w_underflow;
        w_ctrl_rd[CTRL_BUSY_BIT]  = (r_state == ST_CAPTURE);

        if (ctrl_read) begin
            case (ctrl_address)
                ADDR_CTRL:   w_rdata_nxt = w_ctrl_rd;
                ADDR_LENGTH: w_rdata_nxt = 32'(r_length);
                ADDR_DECIM:  w_rdata_nxt = 32'(r_decim);
                default:     w_rdata_nxt = w_status;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_length    <= LVL_W'(DEPTH);
            r_captured  <= '0;
            r_decim     <= '0;
            r_decim_cnt <= '0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_irq       <= 1'b0;
            r_wrreq     <= 1'b0;
            r_data      <= '0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_length    <= w_length_nxt;
            r_captured  <= w_captured_nxt;
            r_decim     <= w_decim_nxt;
            r_decim_cnt <= w_decim_cnt_nxt;
            r_done      <= w_done_nxt;
            r_ovf       <= w_ovf_nxt;
            r_irq       <= w_irq_nxt;
            r_wrreq     <= w_wrreq_nxt;
            r_data      <= w_data_nxt;
            r_rdata     <= w_rdata_nxt;
        end
    end

    assign ctrl_readdata = r_rdata;
    assign fifo_data     = r_data;
    assign fifo_wrreq    = r_wrreq;
    assign irq           = r_irq;

endmodule

// File: tb/tb_fifo_capture_ctrl.sv
// Directed bench for fifo_capture_ctrl: register map, decimation, overflow, level mirror, abort, reset.
module tb_fifo_capture_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ctrl_address = '0;
    logic        ctrl_write = 1'b0;
    logic [31:0] ctrl_writedata = '0;
    logic        ctrl_read = 1'b0;
    logic [31:0] ctrl_readdata;
    logic [31:0] snk_data = '0;
    logic        snk_valid = 1'b0;
    logic [31:0] fifo_data;
    logic        fifo_wrreq;
    logic        rd_strobe = 1'b0;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] wr_q[$];

    fifo_capture_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_address   (ctrl_address),
        .ctrl_write     (ctrl_write),
        .ctrl_writedata (ctrl_writedata),
        .ctrl_read      (ctrl_read),
        .ctrl_readdata  (ctrl_readdata),
        .snk_data       (snk_data),
        .snk_valid      (snk_valid),
        .fifo_data      (fifo_data),
        .fifo_wrreq     (fifo_wrreq),
        .rd_strobe      (rd_strobe),
        .irq            (irq)
    );

    always #5 clock = ~clock;

    // Record every word presented to the FIFO
    always @(negedge clock) begin
        if (fifo_wrreq === 1'b1) wr_q.push_back(fifo_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        wr_q.delete();
    endtask

    task automatic ctrl_wr(input logic [1:0] addr, input logic [31:0] data);
        ctrl_address   = addr;
        ctrl_writedata = data;
        ctrl_write     = 1'b1;
        @(negedge clock);
        ctrl_write     = 1'b0;
    endtask

    task automatic ctrl_rd(input logic [1:0] addr, output logic [31:0] data);
        ctrl_address = addr;
        ctrl_read    = 1'b1;
        @(negedge clock);
        ctrl_read    = 1'b0;
        data         = ctrl_readdata;
    endtask

    task automatic send(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            snk_data  = 32'(first + i);
            snk_valid = 1'b1;
            @(negedge clock);
        end
        snk_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int irq_at;
        logic [31:0] exp2 [4];
        exp2[0] = 32'd0; exp2[1] = 32'd4; exp2[2] = 32'd8; exp2[3] = 32'd12;

        // Reset values
        do_reset();
        check("rst_readdata", ctrl_readdata, 32'd0);
        check("rst_wrreq", 32'(fifo_wrreq), 32'd0);
        check("rst_fifo_data", fifo_data, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        ctrl_rd(2'd1, rd); check("rst_length", rd, 32'd128);
        ctrl_rd(2'd2, rd); check("rst_decim", rd, 32'd0);
        ctrl_rd(2'd3, rd); check("rst_status", rd, 32'd0);

        // LENGTH=16, DECIM=0, continuous stream
        ctrl_wr(2'd1, 32'd16);
        ctrl_wr(2'd0, 32'h1);
        ctrl_rd(2'd0, rd); check("t1_busy", rd, 32'd1);
        send(0, 16);
        idle(2);
        check("t1_nwr", 32'(wr_q.size()), 32'd16);
        for (int i = 0; i < wr_q.size(); i++) check("t1_data", wr_q[i], 32'(i));
        ctrl_rd(2'd3, rd); check("t1_status", rd, 32'h0001_0010);
        check("t1_irq", 32'(irq), 32'd1);
        ctrl_rd(2'd0, rd); check("t1_busy_done", rd, 32'd0);
        ctrl_wr(2'd0, 32'h4);
        check("t1_irq_clr", 32'(irq), 32'd0);
        ctrl_rd(2'd3, rd); check("t1_done_kept", rd, 32'h0001_0010);
        ctrl_wr(2'd0, 32'h1);
        ctrl_rd(2'd3, rd); check("t1_restart_clr_done", rd, 32'h0000_0010);

        // DECIM=3, LENGTH=4
        do_reset();
        ctrl_wr(2'd1, 32'd4);
        ctrl_wr(2'd2, 32'd3);
        ctrl_rd(2'd2, rd); check("t2_decim_rb", rd, 32'd3);
        ctrl_wr(2'd0, 32'h1);
        irq_at = 0;
        for (int i = 0; i < 16; i++) begin
            snk_data  = 32'(i);
            snk_valid = 1'b1;
            @(negedge clock);
            if (irq === 1'b1 && irq_at == 0) irq_at = i + 1;
        end
        snk_valid = 1'b0;
        idle(2);
        check("t2_irq_at", 32'(irq_at), 32'd13);
        check("t2_nwr", 32'(wr_q.size()), 32'd4);
        for (int i = 0; i < wr_q.size() && i < 4; i++) check("t2_data", wr_q[i], exp2[i]);

        // LENGTH clamp, fill to DEPTH, then overflow on a full FIFO
        do_reset();
        ctrl_wr(2'd1, 32'd200);
        ctrl_rd(2'd1, rd); check("t3_len_clamp", rd, 32'd128);
        ctrl_wr(2'd1, 32'd0);
        ctrl_rd(2'd1, rd); check("t3_len_zero", rd, 32'd1);
        ctrl_wr(2'd1, 32'd200);
        ctrl_wr(2'd0, 32'h1);
        send(0, 130);
        idle(2);
        check("t3_nwr", 32'(wr_q.size()), 32'd128);
        ctrl_rd(2'd3, rd); check("t3_status_full", rd, 32'h0001_0080);
        ctrl_wr(2'd0, 32'h1);
        send(200, 5);
        idle(2);
        check("t3_nwr_ovf", 32'(wr_q.size()), 32'd128);
        ctrl_rd(2'd3, rd); check("t3_status_ovf", rd, 32'h0002_0080);
        ctrl_wr(2'd0, 32'h2);
        ctrl_wr(2'd0, 32'h1);
        ctrl_rd(2'd3, rd); check("t3_start_clr_ovf", rd, 32'h0000_0080);

        // Drain past empty, then simultaneous write/read at level 5
        do_reset();
        ctrl_wr(2'd1, 32'd16);
        ctrl_wr(2'd0, 32'h1);
        send(0, 16);
        idle(2);
        rd_strobe = 1'b1;
        idle(17);
        rd_strobe = 1'b0;
        ctrl_rd(2'd3, rd); check("t4_drain_udf", rd, 32'h0005_0000);
        ctrl_wr(2'd0, 32'h1);
        send(0, 5);
        idle(2);
        ctrl_rd(2'd3, rd); check("t4_level5", rd, 32'h0000_0005);
        snk_data  = 32'd99;
        snk_valid = 1'b1;
        @(negedge clock);
        snk_valid = 1'b0;
        rd_strobe = 1'b1;
        check("t4_wr_rd_same", 32'(fifo_wrreq), 32'd1);
        @(negedge clock);
        rd_strobe = 1'b0;
        idle(1);
        ctrl_rd(2'd3, rd); check("t4_level_same", rd, 32'h0000_0005);

        // Abort mid-capture; start+abort in IDLE is ignored
        do_reset();
        ctrl_wr(2'd1, 32'd16);
        ctrl_wr(2'd0, 32'h1);
        send(0, 5);
        ctrl_wr(2'd0, 32'h2);
        idle(1);
        ctrl_rd(2'd0, rd); check("t5_abort_idle", rd, 32'd0);
        check("t5_abort_irq", 32'(irq), 32'd0);
        ctrl_rd(2'd3, rd); check("t5_abort_status", rd, 32'h0000_0005);
        ctrl_wr(2'd0, 32'h3);
        ctrl_rd(2'd0, rd); check("t5_start_abort", rd, 32'd0);

        // Reset mid-capture at sample 7
        do_reset();
        ctrl_wr(2'd1, 32'd16);
        ctrl_wr(2'd0, 32'h1);
        ctrl_rd(2'd1, rd); check("t6_len_pre", rd, 32'd16);
        send(0, 6);
        snk_data  = 32'd6;
        snk_valid = 1'b1;
        reset     = 1'b1;
        @(negedge clock);
        check("t6_wrreq", 32'(fifo_wrreq), 32'd0);
        check("t6_irq", 32'(irq), 32'd0);
        check("t6_readdata", ctrl_readdata, 32'd0);
        reset     = 1'b0;
        snk_valid = 1'b0;
        ctrl_rd(2'd3, rd); check("t6_level", rd, 32'd0);
        ctrl_rd(2'd1, rd); check("t6_length", rd, 32'd128);
        ctrl_rd(2'd0, rd); check("t6_idle", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
